// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarder round-robin arbiter.
//   fwd_state_e        : arbiter FSM state encoding
//   FWD_N_SRC_DEF      : default number of packet buffers
//   FWD_ADDR_WIDTH_DEF : default buffer word-address width
package fwd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_RELEASE = 2'd3
   } fwd_state_e;

   localparam int unsigned FWD_N_SRC_DEF      = 3;
   localparam int unsigned FWD_ADDR_WIDTH_DEF = 10;

endpackage

// File: rtl/fwd_rr_pick.sv
// Combinational rotate-priority picker.
// Scans rdy_i starting at ptr_i+1 (mod N_SRC) and grants the first set bit.
// Ports:
//   rdy_i  in  N_SRC   request vector
//   ptr_i  in  PW      index of the last granted source
//   gnt_o  out N_SRC   one-hot grant (zero when nothing requested)
//   vld_o  out 1       a grant was made
module fwd_rr_pick
   import fwd_pkg::*;
#(
   parameter int unsigned N_SRC = FWD_N_SRC_DEF,
   parameter int unsigned PW    = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] rdy_i,
   input  logic [PW-1:0]    ptr_i,
   output logic [N_SRC-1:0] gnt_o,
   output logic             vld_o
);

   logic [31:0] idx;

   always_comb begin
      gnt_o = '0;
      vld_o = 1'b0;
      idx   = '0;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         idx = (32'(ptr_i) + k) % N_SRC;
         if (!vld_o && rdy_i[idx[PW-1:0]]) begin
            gnt_o[idx[PW-1:0]] = 1'b1;
            vld_o              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/forwarder_rr_arbiter.sv
// Round-robin arbiter and word streamer sitting in front of the forwarder's
// one-hot data muxes. Grants one finished packet buffer at a time, reads it
// out word by word (1-cycle buffer latency) and releases it with src_done.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   src_rdy     buffer i holds a complete packet
//   src_len     packet length per buffer, slice i = [i*(AW+1) +: AW+1]
//   src_done    one-cycle release pulse for the forwarded buffer
//   sel         one-hot mux select, zero when idle
//   rd_en       read enable to the selected buffer
//   rd_addr     word address to the selected buffer
//   out_vld     output word valid
//   out_last    final word of the packet
//   out_rdy     downstream accept
//   pkt_count   forwarded packet counter (only with FWD_PKT_COUNT_EN)
// Build option: define FWD_PKT_COUNT_EN to add pkt_count.
//
// state   | meaning
// IDLE    | sel=0, pick next ready buffer, latch its length
// READ    | issue reads while the output register can take a word
// DRAIN   | all reads issued, wait for the last word to be accepted
// RELEASE | pulse src_done, move priority pointer, clear sel
module forwarder_rr_arbiter
   import fwd_pkg::*;
#(
   parameter int unsigned N_SRC      = FWD_N_SRC_DEF,
   parameter int unsigned ADDR_WIDTH = FWD_ADDR_WIDTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [N_SRC-1:0]                  src_rdy,
   input  logic [N_SRC*(ADDR_WIDTH+1)-1:0]   src_len,
   output logic [N_SRC-1:0]                  src_done,
   output logic [N_SRC-1:0]                  sel,
   output logic                              rd_en,
   output logic [ADDR_WIDTH-1:0]             rd_addr,
   output logic                              out_vld,
   output logic                              out_last,
   input  logic                              out_rdy
`ifdef FWD_PKT_COUNT_EN
   ,
   output logic [31:0]                       pkt_count
`endif
);

   localparam int unsigned LW = ADDR_WIDTH + 1;
   localparam int unsigned PW = $clog2(N_SRC);
   localparam logic [LW-1:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   fwd_state_e            state_q;
   logic [PW-1:0]         ptr_q;
   logic [N_SRC-1:0]      sel_q;
   logic [N_SRC-1:0]      done_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [ADDR_WIDTH-1:0] last_addr_q;
   logic                  out_vld_q;
   logic                  out_last_q;

   logic [N_SRC-1:0]      pick_gnt;
   logic                  pick_vld;
   logic [LW-1:0]         len_raw;
   logic [LW-1:0]         len_clamp;
   logic [PW-1:0]         sel_idx;
   logic                  rd_en_c;
   logic                  accept;

   fwd_rr_pick #(.N_SRC(N_SRC), .PW(PW)) u_pick (
      .rdy_i (src_rdy),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .vld_o (pick_vld)
   );

   // Length of the buffer being granted; lengths beyond the address space
   // are clamped so the address counter can never run past the buffer.
   always_comb begin
      len_raw = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (pick_gnt[i]) len_raw = len_raw | src_len[i*LW +: LW];
      end
      len_clamp = (len_raw > LEN_MAX) ? LEN_MAX : len_raw;
   end

   always_comb begin
      sel_idx = '0;
      for (int i = 0; i < int'(N_SRC); i++) begin
         if (sel_q[i]) sel_idx = PW'(i);
      end
   end

   // A read may be issued whenever the output register is empty or is
   // being emptied this cycle; the buffers hold their data otherwise.
   assign rd_en_c = (state_q == ST_READ) && (!out_vld_q || out_rdy);
   assign accept  = out_vld_q && out_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= PW'(N_SRC - 1);
         sel_q       <= '0;
         done_q      <= '0;
         rd_addr_q   <= '0;
         last_addr_q <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         done_q <= '0;

         if (rd_en_c) begin
            out_vld_q  <= 1'b1;
            out_last_q <= (rd_addr_q == last_addr_q);
         end else if (out_rdy) begin
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  sel_q       <= pick_gnt;
                  rd_addr_q   <= '0;
                  last_addr_q <= ADDR_WIDTH'(len_clamp - 1'b1);
                  if (len_clamp == '0) begin
                     done_q  <= pick_gnt;
                     state_q <= ST_RELEASE;
                  end else begin
                     state_q <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (rd_en_c) begin
                  rd_addr_q <= rd_addr_q + 1'b1;
                  if (rd_addr_q == last_addr_q) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (accept && out_last_q) begin
                  done_q  <= sel_q;
                  state_q <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               ptr_q     <= sel_idx;
               sel_q     <= '0;
               rd_addr_q <= '0;
               state_q   <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef FWD_PKT_COUNT_EN
   logic [31:0] pkt_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     pkt_cnt_q <= '0;
      else if (state_q == ST_RELEASE) pkt_cnt_q <= pkt_cnt_q + 32'd1;
   end

   assign pkt_count = pkt_cnt_q;
`endif

   assign sel      = sel_q;
   assign src_done = done_q;
   assign rd_en    = rd_en_c;
   assign rd_addr  = rd_addr_q;
   assign out_vld  = out_vld_q;
   assign out_last = out_last_q;

endmodule
